// File: rtl/obstacle_scheduler.sv
// Obstacle scroll scheduler: on each frame trigger, moves four obstacles left one per cycle,
// wraps them past the left edge with a fresh LFSR-derived gap, and flags frame/wrap events.
module obstacle_scheduler #(
  parameter int unsigned SPEED   = 2,
  parameter int unsigned SPACING = 160,
  parameter int unsigned WRAP_X  = 640,
  parameter int unsigned GAP_MIN = 40,
  parameter int unsigned V_TRIG  = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       start,
  input  logic       halt,
  input  logic       pause,
  output logic [9:0] X_Edge_O1,
  output logic [9:0] X_Edge_O2,
  output logic [9:0] X_Edge_O3,
  output logic [9:0] X_Edge_O4,
  output logic [9:0] Y_Edge_O1,
  output logic [9:0] Y_Edge_O2,
  output logic [9:0] Y_Edge_O3,
  output logic [9:0] Y_Edge_O4,
  output logic       frame_tick,
  output logic       busy,
  output logic       wrap_pulse
);

  localparam logic [9:0] SPEED_W  = 10'(SPEED);
  localparam logic [9:0] WRAP_W   = 10'(WRAP_X);
  localparam logic [9:0] GAP_W    = 10'(GAP_MIN);
  localparam logic [9:0] V_TRIG_W = 10'(V_TRIG);
  localparam logic [9:0] Y_RESET  = 10'd200;

  typedef enum logic [2:0] {
    IDLE,
    RUN_WAIT,
    UPD1,
    UPD2,
    UPD3,
    UPD4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] x_q [4];
  logic [9:0] y_q [4];
  logic [9:0] lfsr;

  logic       frame_det;
  logic       upd_en;
  logic [1:0] upd_idx;
  logic [9:0] x_cur;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       wrap;

  assign frame_det = (CounterX == '0) && (CounterY == V_TRIG_W);

  // Entering UPD1 on the trigger edge itself lines busy up with frame_tick,
  // so obstacle n lands n+1 cycles after the trigger.
  always_comb begin
    state_nxt = state;
    upd_en    = 1'b0;
    upd_idx   = 2'd0;
    case (state)
      IDLE: begin
        if (start && !halt) state_nxt = RUN_WAIT;
      end
      RUN_WAIT: begin
        if (halt)                     state_nxt = IDLE;
        else if (frame_det && !pause) state_nxt = UPD1;
      end
      UPD1: begin
        upd_en    = 1'b1;
        upd_idx   = 2'd0;
        state_nxt = halt ? IDLE : UPD2;
      end
      UPD2: begin
        upd_en    = 1'b1;
        upd_idx   = 2'd1;
        state_nxt = halt ? IDLE : UPD3;
      end
      UPD3: begin
        upd_en    = 1'b1;
        upd_idx   = 2'd2;
        state_nxt = halt ? IDLE : UPD4;
      end
      UPD4: begin
        upd_en    = 1'b1;
        upd_idx   = 2'd3;
        state_nxt = halt ? IDLE : RUN_WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_cur  = x_q[upd_idx];
    wrap   = x_cur < SPEED_W;
    x_next = wrap ? (x_cur + WRAP_W - SPEED_W) : (x_cur - SPEED_W);
    y_next = GAP_W + {2'b00, lfsr[7:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
      lfsr       <= 10'h001;
      for (int unsigned i = 0; i < 4; i++) begin
        x_q[i] <= 10'(480 + i * SPACING);
        y_q[i] <= Y_RESET;
      end
    end else begin
      state      <= state_nxt;
      frame_tick <= frame_det;
      busy       <= (state_nxt == UPD1) || (state_nxt == UPD2) ||
                    (state_nxt == UPD3) || (state_nxt == UPD4);
      wrap_pulse <= upd_en && wrap;
      lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if (upd_en) begin
        x_q[upd_idx] <= x_next;
        if (wrap) y_q[upd_idx] <= y_next;
      end
    end
  end

  assign X_Edge_O1 = x_q[0];
  assign X_Edge_O2 = x_q[1];
  assign X_Edge_O3 = x_q[2];
  assign X_Edge_O4 = x_q[3];
  assign Y_Edge_O1 = y_q[0];
  assign Y_Edge_O2 = y_q[1];
  assign Y_Edge_O3 = y_q[2];
  assign Y_Edge_O4 = y_q[3];

endmodule
